// File: rtl/arp_resolver.sv
// ARP initiator: broadcasts who-has for a queried IPv4 address, retries on timeout, reports the MAC.
// Optional ARP_RESOLVER_PASSIVE_LEARN_EN also resolves from OPER=1 frames whose sender is the pending IP.

typedef struct packed {
   logic        start;
   logic [31:0] data;
   logic [2:0]  bytes_valid;
   logic        commit;
   logic        drop;
} EthernetBus;

module arp_resolver #(
   parameter int unsigned TIMEOUT_CYCLES = 1250000,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] our_mac_address,
   input  logic [31:0] our_ip_address,
   input  logic        query_en,
   input  logic [31:0] query_ip,
   output logic        query_busy,
   output logic        result_valid,
   output logic        result_ok,
   output logic [47:0] result_mac,
   input  EthernetBus  rx_l2_bus,
   input  logic        rx_l2_headers_valid,
   input  logic        rx_l2_ethertype_is_arp,
   output EthernetBus  tx_l2_bus,
   output logic [47:0] tx_l2_dst_mac
);

   localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;
   typedef enum logic [1:0] {P_IDLE, P_HDR, P_WORDS, P_TAIL} pstate_t;

   state_t        r_state;
   logic          r_busy;
   logic          r_result_valid;
   logic          r_result_ok;
   logic [47:0]   r_result_mac;
   EthernetBus    r_tx;
   logic [47:0]   r_dst_mac;
   logic [3:0]    r_beat;
   logic [RW-1:0] r_retries;
   logic [TW-1:0] r_timer;
   logic [31:0]   r_pending_ip;
   logic          r_hit;
   logic [47:0]   r_hit_mac;

   pstate_t       r_pstate;
   logic [2:0]    r_pidx;
   logic [47:0]   r_sha;
   logic [31:0]   r_spa;
   logic [31:0]   r_tpa;
   logic          r_oper_req;

   logic          w_word;
   logic          w_field_ok;
   logic          w_word_ok;
   logic          w_oper_is_reply;
   logic          w_oper_is_req;
   logic          w_rx_done;
   logic          w_match;
   logic [31:0]   w_tx_word;

   assign query_busy    = r_busy;
   assign result_valid  = r_result_valid;
   assign result_ok     = r_result_ok;
   assign result_mac    = r_result_mac;
   assign tx_l2_bus     = r_tx;
   assign tx_l2_dst_mac = r_dst_mac;

   // ---------------- RX parser: field checks on the current word
   assign w_word          = (rx_l2_bus.bytes_valid != 3'd0);
   assign w_oper_is_reply = (rx_l2_bus.data[15:0] == 16'h0002);
`ifdef ARP_RESOLVER_PASSIVE_LEARN_EN
   assign w_oper_is_req   = (rx_l2_bus.data[15:0] == 16'h0001);
`else
   assign w_oper_is_req   = 1'b0;
`endif

   always_comb begin
      w_field_ok = 1'b1;
      if (r_pidx == 3'd0)
         w_field_ok = (rx_l2_bus.data == 32'h00010800);
      else if (r_pidx == 3'd1)
         w_field_ok = (rx_l2_bus.data[31:16] == 16'h0604) && (w_oper_is_reply || w_oper_is_req);
   end

   assign w_word_ok = (rx_l2_bus.bytes_valid == 3'd4) && w_field_ok;
   assign w_rx_done = (r_pstate == P_TAIL) && rx_l2_bus.commit && !rx_l2_bus.start && !rx_l2_bus.drop;
   // A request frame (only possible with passive learning) waives the TPA check.
   assign w_match   = w_rx_done && (r_spa == r_pending_ip) &&
                      ((r_tpa == our_ip_address) || r_oper_req);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pstate <= P_IDLE;
         r_pidx   <= 3'd0;
      end else if (rx_l2_bus.start) begin
         r_pstate <= P_HDR;
      end else if (rx_l2_bus.drop) begin
         r_pstate <= P_IDLE;
      end else begin
         case (r_pstate)
            P_HDR: begin
               if (rx_l2_headers_valid) begin
                  r_pidx   <= 3'd0;
                  r_pstate <= rx_l2_ethertype_is_arp ? P_WORDS : P_IDLE;
               end
            end
            P_WORDS: begin
               if (rx_l2_bus.commit)
                  r_pstate <= P_IDLE;
               else if (w_word) begin
                  if (!w_word_ok)
                     r_pstate <= P_IDLE;
                  else if (r_pidx == 3'd6)
                     r_pstate <= P_TAIL;
                  else
                     r_pidx <= r_pidx + 3'd1;
               end
            end
            P_TAIL: begin
               if (rx_l2_bus.commit)
                  r_pstate <= P_IDLE;
            end
            default: r_pstate <= P_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_pstate == P_WORDS && w_word) begin
         case (r_pidx)
            3'd1: r_oper_req <= w_oper_is_req;
            3'd2: r_sha[47:16] <= rx_l2_bus.data;
            3'd3: begin
               r_sha[15:0]  <= rx_l2_bus.data[31:16];
               r_spa[31:16] <= rx_l2_bus.data[15:0];
            end
            3'd4: r_spa[15:0] <= rx_l2_bus.data[31:16];
            3'd6: r_tpa <= rx_l2_bus.data;
            default: ;
         endcase
      end
   end

   // ---------------- TX request payload, indexed by beat
   always_comb begin
      w_tx_word = 32'h0;
      case (r_beat)
         4'd1: w_tx_word = 32'h00010800;
         4'd2: w_tx_word = 32'h06040001;
         4'd3: w_tx_word = our_mac_address[47:16];
         4'd4: w_tx_word = {our_mac_address[15:0], our_ip_address[31:16]};
         4'd5: w_tx_word = {our_ip_address[15:0], 16'h0};
         4'd7: w_tx_word = r_pending_ip;
         default: w_tx_word = 32'h0;
      endcase
   end

   // ---------------- Main FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_ok    <= 1'b0;
         r_result_mac   <= 48'h0;
         r_tx           <= '0;
         r_dst_mac      <= 48'h0;
         r_beat         <= 4'd0;
         r_retries      <= '0;
         r_timer        <= '0;
         r_hit          <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         r_tx           <= '0;
         r_dst_mac      <= 48'h0;
         case (r_state)
            S_IDLE: begin
               r_hit <= 1'b0;
               // Busy stays high through the result cycle, so a query there is dropped.
               if (r_busy)
                  r_busy <= 1'b0;
               else if (query_en) begin
                  r_pending_ip <= query_ip;
                  r_retries    <= '0;
                  r_busy       <= 1'b1;
                  r_tx.start   <= 1'b1;
                  r_dst_mac    <= '1;
                  r_beat       <= 4'd1;
                  r_state      <= S_SEND;
               end
            end
            S_SEND: begin
               r_dst_mac <= '1;
               // A reply finishing mid-frame is held until the commit beat has gone out.
               if (w_match) begin
                  r_hit     <= 1'b1;
                  r_hit_mac <= r_sha;
               end
               if (r_beat == 4'd8) begin
                  r_tx.commit <= 1'b1;
                  r_timer     <= TW'(TIMEOUT_CYCLES);
                  r_state     <= S_WAIT;
               end else begin
                  r_tx.data        <= w_tx_word;
                  r_tx.bytes_valid <= 3'd4;
                  r_beat           <= r_beat + 4'd1;
               end
            end
            S_WAIT: begin
               if (r_hit || w_match) begin
                  r_result_valid <= 1'b1;
                  r_result_ok    <= 1'b1;
                  r_result_mac   <= r_hit ? r_hit_mac : r_sha;
                  r_state        <= S_IDLE;
               end else if (r_timer == TW'(1)) begin
                  if (r_retries < RW'(MAX_RETRIES)) begin
                     r_retries  <= r_retries + RW'(1);
                     r_tx.start <= 1'b1;
                     r_dst_mac  <= '1;
                     r_beat     <= 4'd1;
                     r_state    <= S_SEND;
                  end else begin
                     r_result_valid <= 1'b1;
                     r_result_ok    <= 1'b0;
                     r_state        <= S_IDLE;
                  end
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arp_resolver.sv
// Directed + randomized bench for arp_resolver with a frame-level reference model.
module tb_arp_resolver;
   localparam int TO = 100;
   localparam int MR = 2;
`ifdef ARP_RESOLVER_PASSIVE_LEARN_EN
   localparam bit PASSIVE = 1'b1;
`else
   localparam bit PASSIVE = 1'b0;
`endif

   typedef struct packed {
      logic        start;
      logic [31:0] data;
      logic [2:0]  bytes_valid;
      logic        commit;
      logic        drop;
   } bus_t;

   typedef struct packed {
      bus_t bus;
      logic hv;
      logic arp;
   } rxb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] our_mac;
   logic [31:0] our_ip;
   logic        query_en;
   logic [31:0] query_ip;
   logic        query_busy;
   logic        result_valid;
   logic        result_ok;
   logic [47:0] result_mac;
   bus_t        rx_bus;
   logic        hv;
   logic        arp;
   bus_t        tx_bus;
   logic [47:0] dst_mac;

   int   n_assert = 0;
   int   n_fail   = 0;
   rxb_t rxq[$];

   always #5 clk = ~clk;

   arp_resolver #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .our_mac_address        (our_mac),
      .our_ip_address         (our_ip),
      .query_en               (query_en),
      .query_ip               (query_ip),
      .query_busy             (query_busy),
      .result_valid           (result_valid),
      .result_ok              (result_ok),
      .result_mac             (result_mac),
      .rx_l2_bus              (rx_bus),
      .rx_l2_headers_valid    (hv),
      .rx_l2_ethertype_is_arp (arp),
      .tx_l2_bus              (tx_bus),
      .tx_l2_dst_mac          (dst_mac)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive this cycle's RX beat, then move to just after the next rising edge.
   task automatic step();
      rxb_t b;
      b = '0;
      if (rxq.size() > 0) b = rxq.pop_front();
      rx_bus = b.bus;
      hv     = b.hv;
      arp    = b.arp;
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                             input logic [15:0] oper, input logic is_arp, input int bad_word,
                             input int drop_at, input int npad);
      logic [223:0] pkt;
      rxb_t b;
      pkt = {16'h0001, 16'h0800, 8'h06, 8'h04, oper, sha, spa, 48'h0, tpa};
      b = '0; b.bus.start = 1'b1; rxq.push_back(b);
      b = '0; b.hv = 1'b1; b.arp = is_arp; rxq.push_back(b);
      for (int i = 0; i < 7; i++) begin
         if (i == drop_at) begin
            b = '0; b.hv = 1'b1; b.arp = is_arp; b.bus.drop = 1'b1; rxq.push_back(b);
         end
         b = '0; b.hv = 1'b1; b.arp = is_arp;
         b.bus.data = pkt[223-32*i -: 32];
         b.bus.bytes_valid = (i == bad_word) ? 3'd2 : 3'd4;
         rxq.push_back(b);
      end
      for (int i = 0; i < npad; i++) begin
         b = '0; b.hv = 1'b1; b.arp = is_arp; b.bus.data = $urandom; b.bus.bytes_valid = 3'd4;
         rxq.push_back(b);
      end
      b = '0; b.hv = 1'b1; b.arp = is_arp; b.bus.commit = 1'b1; rxq.push_back(b);
   endtask

   // A frame resolves the pending query when it is a clean ARP frame that names the pending IP as sender.
   function automatic logic model_resolves(input logic [31:0] spa, input logic [31:0] tpa,
                                           input logic [15:0] oper, input logic is_arp,
                                           input int bad_word, input int drop_at,
                                           input logic [31:0] pending);
      if (!is_arp) return 1'b0;
      if (bad_word >= 0 && bad_word < 7) return 1'b0;
      if (drop_at >= 0 && drop_at < 7) return 1'b0;
      if (oper == 16'd2) return (spa == pending) && (tpa == our_ip);
      if (oper == 16'd1) return PASSIVE && (spa == pending);
      return 1'b0;
   endfunction

   // Called in the cycle where the start beat should be visible; returns in the commit cycle.
   task automatic check_frame(input string tag, input logic [31:0] pend);
      logic [223:0] pkt;
      bus_t exp;
      pkt = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, our_mac, our_ip, 48'h0, pend};
      for (int b = 0; b < 9; b++) begin
         exp = '0;
         if (b == 0) exp.start = 1'b1;
         else if (b == 8) exp.commit = 1'b1;
         else begin
            exp.data = pkt[223-32*(b-1) -: 32];
            exp.bytes_valid = 3'd4;
         end
         chk($sformatf("%s_beat%0d", tag, b), 64'(tx_bus), 64'(exp));
         chk($sformatf("%s_dst%0d", tag, b), 64'(dst_mac), 64'hffffffffffff);
         if (b < 8) step();
      end
   endtask

   task automatic do_query(input logic [31:0] ip);
      query_ip = ip;
      query_en = 1'b1;
      step();
      query_en = 1'b0;
   endtask

   // Feed queued RX beats; check the resolution one cycle after the commit beat.
   task automatic run_expect(input string tag, input logic exp, input logic [47:0] mac);
      while (rxq.size() > 0) step();
      chk({tag, "_valid"}, 64'(result_valid), 64'(exp));
      chk({tag, "_busy"}, 64'(query_busy), 64'(1));
      if (exp) begin
         chk({tag, "_ok"}, 64'(result_ok), 64'(1));
         chk({tag, "_mac"}, 64'(result_mac), 64'(mac));
         step();
         chk({tag, "_busy_drop"}, 64'(query_busy), 64'(0));
         chk({tag, "_pulse"}, 64'(result_valid), 64'(0));
      end
   endtask

   task automatic wait_gap(input string tag, output int gap);
      gap = 0;
      do begin
         step();
         gap++;
      end while (!tx_bus.start && !result_valid && gap < 4*TO);
      if (gap >= 4*TO) chk({tag, "_timeout"}, 64'(gap), 64'(TO));
   endtask

   initial begin
      int gap;
      int nz;
      logic exp_res;
      logic [47:0] sha;
      logic [31:0] q, spa, tpa;
      logic [15:0] oper;
      logic is_arp;
      int bad_word, drop_at, variant;

      rst = 1'b1; query_en = 1'b0; query_ip = 32'h0;
      our_mac = 48'h020000000001; our_ip = 32'h0A000001;
      rx_bus = '0; hv = 1'b0; arp = 1'b0;
      repeat (3) step();
      chk("rst_busy", 64'(query_busy), 64'(0));
      chk("rst_valid", 64'(result_valid), 64'(0));
      chk("rst_ok", 64'(result_ok), 64'(0));
      chk("rst_mac", 64'(result_mac), 64'(0));
      chk("rst_tx", 64'(tx_bus), 64'(0));
      chk("rst_dst", 64'(dst_mac), 64'(0));
      rst = 1'b0;
      step();

      // Basic request and reply
      do_query(32'h0A000002);
      chk("q1_busy", 64'(query_busy), 64'(1));
      check_frame("q1", 32'h0A000002);
      step();
      chk("q1_idle_tx", 64'(tx_bus), 64'(0));
      chk("q1_idle_dst", 64'(dst_mac), 64'(0));
      push_frame(48'h020000000002, 32'h0A000002, 32'h0A000001, 16'd2, 1'b1, -1, -1, 4);
      while (rxq.size() > 0) step();
      chk("r1_valid", 64'(result_valid), 64'(1));
      chk("r1_ok", 64'(result_ok), 64'(1));
      chk("r1_mac", 64'(result_mac), 64'h020000000002);
      chk("r1_busy", 64'(query_busy), 64'(1));
      query_ip = 32'h0A000005; query_en = 1'b1;
      step();
      query_en = 1'b0;
      chk("r1_busy_drop", 64'(query_busy), 64'(0));
      chk("r1_ignored_query", 64'(tx_bus), 64'(0));
      chk("r1_mac_hold", 64'(result_mac), 64'h020000000002);

      // Rejected replies, ignored busy query, then a good reply
      do_query(32'h0A000002);
      check_frame("q2", 32'h0A000002);
      push_frame(48'h020000000003, 32'h0A000003, 32'h0A000001, 16'd2, 1'b1, -1, -1, 0);
      run_expect("bad_spa", 1'b0, 48'h0);
      push_frame(48'h020000000003, 32'h0A000002, 32'h0A000001, 16'd2, 1'b1, 2, -1, 0);
      run_expect("bad_bv", 1'b0, 48'h0);
      push_frame(48'h020000000003, 32'h0A000002, 32'h0A000001, 16'd2, 1'b1, -1, 3, 0);
      run_expect("dropped", 1'b0, 48'h0);
      do_query(32'h0A000009);
      nz = 0;
      repeat (3) begin
         if (tx_bus != '0) nz++;
         step();
      end
      chk("busy_query_no_tx", 64'(nz), 64'(0));
      push_frame(48'h02000000000A, 32'h0A000002, 32'h0A000001, 16'd2, 1'b1, -1, -1, 1);
      run_expect("late_good", 1'b1, 48'h02000000000A);

      // Reply completing while the request is still being sent
      push_frame(48'h0200000000BB, 32'h0A000004, 32'h0A000001, 16'd2, 1'b1, -1, -1, 0);
      repeat (3) step();
      do_query(32'h0A000004);
      check_frame("ovl", 32'h0A000004);
      chk("ovl_commit_no_result", 64'(result_valid), 64'(0));
      step();
      chk("ovl_valid", 64'(result_valid), 64'(1));
      chk("ovl_ok", 64'(result_ok), 64'(1));
      chk("ovl_mac", 64'(result_mac), 64'h0200000000BB);
      step();

      // Randomized replies against the model
      for (int it = 0; it < 8; it++) begin
         our_mac = 48'({$urandom, $urandom});
         our_ip  = $urandom;
         q       = $urandom;
         sha     = 48'({$urandom, $urandom});
         spa = q; tpa = our_ip; oper = 16'd2; is_arp = 1'b1; bad_word = -1; drop_at = -1;
         variant = int'($urandom_range(0, 6));
         case (variant)
            1: spa = q ^ 32'h1;
            2: tpa = our_ip ^ 32'h100;
            3: bad_word = int'($urandom_range(0, 6));
            4: drop_at = int'($urandom_range(0, 6));
            5: begin oper = 16'd1; tpa = q; end
            6: is_arp = 1'b0;
            default: ;
         endcase
         exp_res = model_resolves(spa, tpa, oper, is_arp, bad_word, drop_at, q);
         do_query(q);
         check_frame($sformatf("rnd%0d", it), q);
         push_frame(sha, spa, tpa, oper, is_arp, bad_word, drop_at, int'($urandom_range(0, 4)));
         run_expect($sformatf("rnd%0d_v%0d", it, variant), exp_res, sha);
         if (!exp_res) begin
            sha = 48'({$urandom, $urandom});
            push_frame(sha, q, our_ip, 16'd2, 1'b1, -1, -1, 0);
            run_expect($sformatf("rnd%0d_fix", it), 1'b1, sha);
         end
      end

      // Timeout and retries with no reply
      our_mac = 48'h020000000001; our_ip = 32'h0A000001;
      do_query(32'h0A000002);
      check_frame("to0", 32'h0A000002);
      for (int a = 1; a <= MR; a++) begin
         wait_gap($sformatf("to%0d", a), gap);
         chk($sformatf("to%0d_gap", a), 64'(gap), 64'(TO));
         check_frame($sformatf("to%0d", a), 32'h0A000002);
      end
      wait_gap("to_fail", gap);
      chk("to_fail_gap", 64'(gap), 64'(TO));
      chk("to_fail_valid", 64'(result_valid), 64'(1));
      chk("to_fail_ok", 64'(result_ok), 64'(0));
      chk("to_fail_busy", 64'(query_busy), 64'(1));
      step();
      chk("to_fail_busy_drop", 64'(query_busy), 64'(0));

      // Gratuitous request naming the pending IP
      do_query(32'h0A000002);
      check_frame("grat", 32'h0A000002);
      exp_res = model_resolves(32'h0A000002, 32'h0A000002, 16'd1, 1'b1, -1, -1, 32'h0A000002);
      push_frame(48'h0200000000CC, 32'h0A000002, 32'h0A000002, 16'd1, 1'b1, -1, -1, 2);
      run_expect("grat", exp_res, 48'h0200000000CC);
      if (!exp_res) begin
         gap = 0;
         while (!result_valid && gap < 5*TO) begin
            step();
            gap++;
         end
         chk("grat_timeout_valid", 64'(result_valid), 64'(1));
         chk("grat_timeout_ok", 64'(result_ok), 64'(0));
         step();
      end

      // Reset in the middle of a request frame
      do_query(32'h0A000002);
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_tx", 64'(tx_bus), 64'(0));
      chk("mid_rst_dst", 64'(dst_mac), 64'(0));
      chk("mid_rst_busy", 64'(query_busy), 64'(0));
      chk("mid_rst_valid", 64'(result_valid), 64'(0));
      chk("mid_rst_ok", 64'(result_ok), 64'(0));
      chk("mid_rst_mac", 64'(result_mac), 64'(0));
      nz = 0;
      repeat (12) begin
         step();
         if (tx_bus != '0) nz++;
      end
      chk("mid_rst_no_beats", 64'(nz), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
